// File: rtl/axi_stream_dw_downsizer_keep_if.sv
// AXI-Stream bundle for axi_stream_dw_downsizer_keep.
// Width parameters must match the downsizer side it connects to.
interface axi_stream_dw_downsizer_keep_if #(
  parameter int DataWidth = 32,
  parameter int IdWidth   = 1,
  parameter int DestWidth = 1,
  parameter int UserWidth = 1
);
  logic                   tvalid;
  logic                   tready;
  logic [DataWidth-1:0]   tdata;
  logic [DataWidth/8-1:0] tkeep;
  logic [DataWidth/8-1:0] tstrb;
  logic                   tlast;
  logic [IdWidth-1:0]     tid;
  logic [DestWidth-1:0]   tdest;
  logic [UserWidth-1:0]   tuser;

  modport master (
    output tvalid, tdata, tkeep, tstrb,
    output tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tstrb,
    input  tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/axi_stream_dw_downsizer_keep.sv
// N:1 AXI-Stream width downsizer, one-beat buffer, full throughput.
// Define AXIS_DWD_NULL_SKIP_EN to skip lanes whose keep slice is all zero.
module axi_stream_dw_downsizer_keep #(
  parameter int DataWidthIn  = 32,
  parameter int DataWidthOut = 8,
  parameter int IdWidth      = 1,
  parameter int DestWidth    = 1,
  parameter int UserWidth    = 1,
  parameter bit MsbFirst     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  axi_stream_dw_downsizer_keep_if.slave  in,
  axi_stream_dw_downsizer_keep_if.master out
);
  localparam int Ratio = DataWidthIn / DataWidthOut;
  localparam int KwIn  = DataWidthIn / 8;
  localparam int KwOut = DataWidthOut / 8;
  localparam int CW    = (Ratio > 1) ? $clog2(Ratio) : 1;

  if (DataWidthIn % DataWidthOut != 0) begin : g_err_div
    $error("DataWidthIn must be a multiple of DataWidthOut");
  end
  if (Ratio < 2) begin : g_err_ratio
    $error("Ratio must be at least 2");
  end
  if (DataWidthOut % 8 != 0) begin : g_err_byte
    $error("DataWidthOut must be a multiple of 8");
  end

  logic [DataWidthIn-1:0] r_data;
  logic [KwIn-1:0]        r_keep;
  logic [KwIn-1:0]        r_strb;
  logic                   r_last;
  logic [IdWidth-1:0]     r_id;
  logic [DestWidth-1:0]   r_dest;
  logic [UserWidth-1:0]   r_user;
  logic                   r_valid;
  logic [CW-1:0]          r_lane;

  logic [CW-1:0] w_phys;
  logic [CW-1:0] w_first_in;
  logic [CW-1:0] w_next;
  logic          w_final;
  logic          w_drop;
  logic          w_hs;
  logic          w_load;

  // r_lane counts position in emit order; w_phys is the bit lane.
  assign w_phys = MsbFirst ? (CW'(Ratio - 1) - r_lane) : r_lane;

`ifdef AXIS_DWD_NULL_SKIP_EN
  logic [Ratio-1:0] w_nn_buf;
  logic [Ratio-1:0] w_nn_in;

  for (genvar p = 0; p < Ratio; p++) begin : g_nn
    localparam int Ph = MsbFirst ? (Ratio - 1 - p) : p;
    assign w_nn_buf[p] = |r_keep[Ph*KwOut +: KwOut];
    assign w_nn_in[p]  = |in.tkeep[Ph*KwOut +: KwOut];
  end
`endif

  always_comb begin
    w_first_in = '0;
    w_next     = r_lane + CW'(1);
    w_final    = (r_lane == CW'(Ratio - 1));
    w_drop     = 1'b0;
`ifdef AXIS_DWD_NULL_SKIP_EN
    w_next  = r_lane;
    w_final = 1'b1;
    // Descending scan so the lowest qualifying position wins.
    for (int p = Ratio - 1; p >= 0; p--) begin
      if (w_nn_in[p]) begin
        w_first_in = CW'(p);
      end
      if (w_nn_buf[p] && (p > int'(r_lane))) begin
        w_next  = CW'(p);
        w_final = 1'b0;
      end
    end
    w_drop = r_valid && !(|w_nn_buf) && !r_last;
`endif
  end

  assign w_hs   = out.tvalid && out.tready;
  assign w_load = in.tvalid && in.tready;

  assign in.tready  = !r_valid || w_drop ||
                      (w_hs && w_final);
  assign out.tvalid = r_valid && !w_drop;
  assign out.tdata  = r_data[w_phys*DataWidthOut +: DataWidthOut];
  assign out.tkeep  = r_keep[w_phys*KwOut +: KwOut];
  assign out.tstrb  = r_strb[w_phys*KwOut +: KwOut];
  assign out.tlast  = r_last && w_final;
  assign out.tid    = r_id;
  assign out.tdest  = r_dest;
  assign out.tuser  = r_user;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data  <= '0;
      r_keep  <= '0;
      r_strb  <= '0;
      r_last  <= 1'b0;
      r_id    <= '0;
      r_dest  <= '0;
      r_user  <= '0;
      r_valid <= 1'b0;
      r_lane  <= '0;
    end else if (w_load) begin
      r_data  <= in.tdata;
      r_keep  <= in.tkeep;
      r_strb  <= in.tstrb;
      r_last  <= in.tlast;
      r_id    <= in.tid;
      r_dest  <= in.tdest;
      r_user  <= in.tuser;
      r_valid <= 1'b1;
      r_lane  <= w_first_in;
    end else if ((w_hs && w_final) || w_drop) begin
      r_valid <= 1'b0;
      r_lane  <= '0;
    end else if (w_hs) begin
      r_lane  <= w_next;
    end
  end
endmodule

// File: tb/tb_axi_stream_dw_downsizer_keep.sv
// Directed bench for axi_stream_dw_downsizer_keep (32->8).
// Honours AXIS_DWD_NULL_SKIP_EN when the build defines it.
module tb_axi_stream_dw_downsizer_keep;
  logic clk = 1'b0;
  logic rst;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  axi_stream_dw_downsizer_keep_if #(.DataWidth(32)) ia ();
  axi_stream_dw_downsizer_keep_if #(.DataWidth(8))  oa ();
  axi_stream_dw_downsizer_keep_if #(.DataWidth(32)) ib ();
  axi_stream_dw_downsizer_keep_if #(.DataWidth(8))  ob ();

  axi_stream_dw_downsizer_keep #(.MsbFirst(1'b0)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .in    (ia),
    .out   (oa)
  );

  axi_stream_dw_downsizer_keep #(.MsbFirst(1'b1)) u_msb (
    .clk_i (clk),
    .rst_i (rst),
    .in    (ib),
    .out   (ob)
  );

  localparam logic [31:0] A = 32'h1234_56ef;
  localparam logic [31:0] B = 32'ha1b2_c3d4;

  logic [10:0] got;
  logic [10:0] exp;

  task automatic drive(input logic v, input logic [31:0] d,
                       input logic [3:0] k, input logic l);
    ia.tvalid = v;
    ia.tdata  = d;
    ia.tkeep  = k;
    ia.tstrb  = k;
    ia.tlast  = l;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    got = {oa.tvalid, oa.tlast, oa.tkeep, oa.tdata};
    checks++;
    if (got !== 11'd0) begin
      errs++;
      $display("FAIL reset_out got=%h exp=000", got);
    end
    checks++;
    if (ia.tready !== 1'b1) begin
      errs++;
      $display("FAIL reset_tready got=%b exp=1", ia.tready);
    end
  endtask

  task automatic test_basic;
    logic [7:0] e [4];
    e = '{8'hef, 8'h56, 8'h34, 8'h12};
    drive(1'b1, A, 4'hf, 1'b1);
    @(negedge clk);
    drive(1'b0, A, 4'hf, 1'b0);
    for (int k = 0; k < 4; k++) begin
      got = {oa.tvalid, oa.tlast, oa.tkeep, oa.tdata};
      exp = {1'b1, (k == 3), 1'b1, e[k]};
      checks++;
      if (got !== exp) begin
        errs++;
        $display("FAIL basic[%0d] got=%h exp=%h", k, got, exp);
      end
      checks++;
      if ({oa.tid, oa.tuser} !== 2'b11) begin
        errs++;
        $display("FAIL basic_side[%0d] got=%b exp=11",
                 k, {oa.tid, oa.tuser});
      end
      @(negedge clk);
    end
    checks++;
    if (oa.tvalid !== 1'b0) begin
      errs++;
      $display("FAIL basic_idle got=%b exp=0", oa.tvalid);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] e [8];
    e = '{8'hef, 8'h56, 8'h34, 8'h12,
          8'hd4, 8'hc3, 8'hb2, 8'ha1};
    drive(1'b1, A, 4'hf, 1'b0);
    @(negedge clk);
    drive(1'b1, B, 4'hf, 1'b1);
    for (int k = 0; k < 8; k++) begin
      if (k == 4) drive(1'b0, B, 4'hf, 1'b0);
      got = {oa.tvalid, oa.tlast, oa.tkeep, oa.tdata};
      exp = {1'b1, (k == 7), 1'b1, e[k]};
      checks++;
      if (got !== exp) begin
        errs++;
        $display("FAIL b2b[%0d] got=%h exp=%h", k, got, exp);
      end
      if (k == 0 || k == 3) begin
        checks++;
        if (ia.tready !== (k == 3)) begin
          errs++;
          $display("FAIL b2b_tready[%0d] got=%b exp=%b",
                   k, ia.tready, (k == 3));
        end
      end
      @(negedge clk);
    end
    checks++;
    if (oa.tvalid !== 1'b0) begin
      errs++;
      $display("FAIL b2b_idle got=%b exp=0", oa.tvalid);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] e [6];
    logic       rdy [6];
    e   = '{8'hef, 8'h56, 8'h56, 8'h56, 8'h34, 8'h12};
    rdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    drive(1'b1, A, 4'hf, 1'b1);
    @(negedge clk);
    drive(1'b0, A, 4'hf, 1'b0);
    for (int k = 0; k < 6; k++) begin
      if (k == 1) oa.tready = 1'b0;
      got = {oa.tvalid, oa.tlast, oa.tkeep, oa.tdata};
      exp = {1'b1, (k == 5), 1'b1, e[k]};
      checks++;
      if (got !== exp) begin
        errs++;
        $display("FAIL bp[%0d] got=%h exp=%h", k, got, exp);
      end
      if (k >= 2) begin
        checks++;
        if (ia.tready !== rdy[k]) begin
          errs++;
          $display("FAIL bp_tready[%0d] got=%b exp=%b",
                   k, ia.tready, rdy[k]);
        end
      end
      if (k == 3) oa.tready = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (oa.tvalid !== 1'b0) begin
      errs++;
      $display("FAIL bp_idle got=%b exp=0", oa.tvalid);
    end
  endtask

  task automatic test_msb_first;
    logic [7:0] e [4];
    e = '{8'h12, 8'h34, 8'h56, 8'hef};
    ib.tvalid = 1'b1;
    ib.tdata  = A;
    ib.tkeep  = 4'hf;
    ib.tstrb  = 4'hf;
    ib.tlast  = 1'b1;
    @(negedge clk);
    ib.tvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      got = {ob.tvalid, ob.tlast, ob.tkeep, ob.tdata};
      exp = {1'b1, (k == 3), 1'b1, e[k]};
      checks++;
      if (got !== exp) begin
        errs++;
        $display("FAIL msb[%0d] got=%h exp=%h", k, got, exp);
      end
      @(negedge clk);
    end
    checks++;
    if (ob.tvalid !== 1'b0) begin
      errs++;
      $display("FAIL msb_idle got=%b exp=0", ob.tvalid);
    end
  endtask

  task automatic test_keep;
`ifdef AXIS_DWD_NULL_SKIP_EN
    logic [10:0] x [2];
    x = '{{1'b1, 1'b0, 1'b1, 8'hef},
          {1'b1, 1'b1, 1'b1, 8'h56}};
    drive(1'b1, A, 4'b0011, 1'b1);
    @(negedge clk);
    drive(1'b0, A, 4'hf, 1'b0);
    for (int k = 0; k < 2; k++) begin
      got = {oa.tvalid, oa.tlast, oa.tkeep, oa.tdata};
      checks++;
      if (got !== x[k]) begin
        errs++;
        $display("FAIL keep[%0d] got=%h exp=%h", k, got, x[k]);
      end
      @(negedge clk);
    end
    checks++;
    if (oa.tvalid !== 1'b0) begin
      errs++;
      $display("FAIL keep_idle got=%b exp=0", oa.tvalid);
    end
    drive(1'b1, A, 4'b0000, 1'b1);
    @(negedge clk);
    drive(1'b0, A, 4'hf, 1'b0);
    got = {oa.tvalid, oa.tlast, oa.tkeep, oa.tdata};
    checks++;
    if (got !== {1'b1, 1'b1, 1'b0, 8'hef}) begin
      errs++;
      $display("FAIL null_last got=%h exp=6ef", got);
    end
    @(negedge clk);
    checks++;
    if (oa.tvalid !== 1'b0) begin
      errs++;
      $display("FAIL null_last_idle got=%b exp=0", oa.tvalid);
    end
    drive(1'b1, A, 4'b0000, 1'b0);
    @(negedge clk);
    drive(1'b1, B, 4'hf, 1'b1);
    checks++;
    if ({oa.tvalid, ia.tready} !== 2'b01) begin
      errs++;
      $display("FAIL null_drop got=%b exp=01",
               {oa.tvalid, ia.tready});
    end
    @(negedge clk);
    drive(1'b0, B, 4'hf, 1'b0);
    got = {oa.tvalid, oa.tlast, oa.tkeep, oa.tdata};
    checks++;
    if (got !== {1'b1, 1'b0, 1'b1, 8'hd4}) begin
      errs++;
      $display("FAIL null_next got=%h exp=5d4", got);
    end
    repeat (4) @(negedge clk);
`else
    logic [10:0] x [4];
    x = '{{1'b1, 1'b0, 1'b1, 8'hef},
          {1'b1, 1'b0, 1'b1, 8'h56},
          {1'b1, 1'b0, 1'b0, 8'h34},
          {1'b1, 1'b1, 1'b0, 8'h12}};
    drive(1'b1, A, 4'b0011, 1'b1);
    @(negedge clk);
    drive(1'b0, A, 4'hf, 1'b0);
    for (int k = 0; k < 4; k++) begin
      got = {oa.tvalid, oa.tlast, oa.tkeep, oa.tdata};
      checks++;
      if (got !== x[k]) begin
        errs++;
        $display("FAIL keep[%0d] got=%h exp=%h", k, got, x[k]);
      end
      @(negedge clk);
    end
    checks++;
    if (oa.tvalid !== 1'b0) begin
      errs++;
      $display("FAIL keep_idle got=%b exp=0", oa.tvalid);
    end
`endif
  endtask

  task automatic test_reset_mid;
    logic [7:0] e [4];
    e = '{8'hef, 8'h56, 8'h34, 8'h12};
    drive(1'b1, A, 4'hf, 1'b1);
    @(negedge clk);
    drive(1'b0, A, 4'hf, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({oa.tvalid, ia.tready} !== 2'b01) begin
      errs++;
      $display("FAIL rstmid got=%b exp=01",
               {oa.tvalid, ia.tready});
    end
    drive(1'b1, A, 4'hf, 1'b1);
    @(negedge clk);
    drive(1'b0, A, 4'hf, 1'b0);
    for (int k = 0; k < 4; k++) begin
      got = {oa.tvalid, oa.tlast, oa.tkeep, oa.tdata};
      exp = {1'b1, (k == 3), 1'b1, e[k]};
      checks++;
      if (got !== exp) begin
        errs++;
        $display("FAIL rstmid[%0d] got=%h exp=%h", k, got, exp);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout errs=%0d checks=%0d", errs, checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'd0, 4'h0, 1'b0);
    ia.tid    = 1'b1;
    ia.tdest  = 1'b0;
    ia.tuser  = 1'b1;
    oa.tready = 1'b1;
    ib.tvalid = 1'b0;
    ib.tdata  = 32'd0;
    ib.tkeep  = 4'h0;
    ib.tstrb  = 4'h0;
    ib.tlast  = 1'b0;
    ib.tid    = 1'b0;
    ib.tdest  = 1'b0;
    ib.tuser  = 1'b0;
    ob.tready = 1'b1;
    test_reset;
    test_basic;
    test_back_to_back;
    test_backpressure;
    test_msb_first;
    test_keep;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
